// File: rtl/adc_scan_scheduler_if.sv
// adc_scan_scheduler_if: control, ADC handshake and result signals of the scan scheduler
interface adc_scan_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 12
);
  localparam int CW = $clog2(NUM_CH);
  logic              enable;
  logic [NUM_CH-1:0] ch_mask;
  logic              err_clr;
  logic              conv_start;
  logic [CW-1:0]     conv_ch;
  logic              conv_done;
  logic [DATA_W-1:0] conv_data;
  logic              result_valid;
  logic [CW-1:0]     result_ch;
  logic [DATA_W-1:0] result_data;
  logic              scan_done;
  logic              busy;
  logic              timeout_err;
  logic              overrun;
  modport slave (
    input  enable, ch_mask, err_clr, conv_done, conv_data,
    output conv_start, conv_ch, result_valid, result_ch, result_data,
           scan_done, busy, timeout_err, overrun
  );
  modport master (
    output enable, ch_mask, err_clr, conv_done, conv_data,
    input  conv_start, conv_ch, result_valid, result_ch, result_data,
           scan_done, busy, timeout_err, overrun
  );
endinterface

// File: rtl/adc_scan_scheduler.sv
// adc_scan_scheduler: tick-driven scan of the enabled channels over one shared ADC
module adc_scan_scheduler #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 12,
  parameter int SAMPLE_DIV = 100000,
  parameter int TIMEOUT    = 1024
) (
  input logic clk,
  input logic reset,
  adc_scan_scheduler_if.slave bus
);
  localparam int CW = $clog2(NUM_CH);
  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int OW = $clog2(TIMEOUT);
  typedef enum logic [4:0] {
    IDLE      = 5'b00001,
    START     = 5'b00010,
    WAIT_DONE = 5'b00100,
    STORE     = 5'b01000,
    NEXT      = 5'b10000
  } state_t;
  state_t            state;
  logic [NUM_CH-1:0] mask;
  logic [TW-1:0]     tick_cnt;
  logic [OW-1:0]     to_cnt;
  logic              tick_pending;
  logic              tc, consume, start_scan, to_hit;
  logic [CW:0]       first, nxt;
  // {found, index} of the lowest set bit strictly above 'from'
  function automatic logic [CW:0] find(input logic [NUM_CH-1:0] m, input int from);
    find = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i] && i > from) find = {1'b1, CW'(i)};
  endfunction
  always_comb begin
    tc         = bus.enable && tick_cnt == TW'(SAMPLE_DIV - 1);
    start_scan = state == IDLE && tick_pending && bus.enable && |bus.ch_mask;
    consume    = state == IDLE && tick_pending && (bus.enable || bus.ch_mask == '0);
    to_hit     = state == WAIT_DONE && !bus.conv_done && to_cnt == OW'(TIMEOUT - 1);
    first      = find(bus.ch_mask, -1);
    nxt        = find(mask, int'(bus.conv_ch));
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      mask             <= '0;
      tick_cnt         <= '0;
      to_cnt           <= '0;
      tick_pending     <= 1'b0;
      bus.conv_start   <= 1'b0;
      bus.conv_ch      <= '0;
      bus.result_valid <= 1'b0;
      bus.result_ch    <= '0;
      bus.result_data  <= '0;
      bus.scan_done    <= 1'b0;
      bus.busy         <= 1'b0;
      bus.timeout_err  <= 1'b0;
      bus.overrun      <= 1'b0;
    end else begin
      bus.conv_start   <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.scan_done    <= 1'b0;
      tick_cnt         <= (!bus.enable || tc) ? '0 : tick_cnt + 1'b1;
      tick_pending     <= tc || (tick_pending && !consume);
      bus.overrun      <= !bus.err_clr && (bus.overrun || (tc && tick_pending && !consume));
      bus.timeout_err  <= !bus.err_clr && (bus.timeout_err || to_hit);
      case (state)
        IDLE: if (start_scan) begin
          mask           <= bus.ch_mask;
          bus.conv_ch    <= first[CW-1:0];
          bus.conv_start <= 1'b1;
          bus.busy       <= 1'b1;
          state          <= START;
        end
        START: begin
          to_cnt <= '0;
          state  <= WAIT_DONE;
        end
        WAIT_DONE: if (bus.conv_done) begin
          bus.result_data  <= bus.conv_data;
          bus.result_ch    <= bus.conv_ch;
          bus.result_valid <= 1'b1;
          state            <= STORE;
        end else if (to_hit) state <= NEXT;
        else to_cnt <= to_cnt + 1'b1;
        STORE: state <= NEXT;
        NEXT: if (nxt[CW] && bus.enable) begin
          bus.conv_ch    <= nxt[CW-1:0];
          bus.conv_start <= 1'b1;
          state          <= START;
        end else begin
          bus.scan_done <= !nxt[CW];
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_adc_scan_scheduler.sv
// tb_adc_scan_scheduler: directed and randomized scans against a channel-list reference model
module tb_adc_scan_scheduler;
  localparam int SD = 128;
  localparam int TO = 1024;
  logic clk = 1'b0;
  logic reset;
  int checks = 0, errors = 0;
  int n_start = 0, n_valid = 0, n_done = 0;
  logic [11:0] fdat [4] = '{12'h123, 12'hABC, 12'h456, 12'h5A5};
  adc_scan_scheduler_if #(.NUM_CH(4), .DATA_W(12)) bus ();
  adc_scan_scheduler #(.NUM_CH(4), .DATA_W(12), .SAMPLE_DIV(SD), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    n_start += int'(bus.conv_start);
    n_valid += int'(bus.result_valid);
    n_done  += int'(bus.scan_done);
  end
  function automatic logic [31:0] outs();
    return 32'({bus.conv_start, bus.conv_ch, bus.result_valid, bus.result_ch, bus.result_data,
                bus.scan_done, bus.busy, bus.timeout_err, bus.overrun});
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_start(input int bound, output int waited);
    waited = 0;
    do begin @(negedge clk); waited++; end while (!bus.conv_start && waited < bound);
    chk("start_seen", 32'(bus.conv_start), 1);
  endtask
  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    reset = 1'b1;
  endtask
  task automatic done_pulse(input int d, input logic [11:0] dat, input int ch, input string tag);
    repeat (d) @(negedge clk);
    bus.conv_done = 1'b1;
    bus.conv_data = dat;
    @(negedge clk);
    bus.conv_done = 1'b0;
    bus.conv_data = 12'($urandom);
    chk({tag, "_valid"}, 32'(bus.result_valid), 1);
    chk({tag, "_ch"}, 32'(bus.result_ch), 32'(ch));
    chk({tag, "_data"}, 32'(bus.result_data), 32'(dat));
  endtask
  task automatic run_scan(input logic [3:0] m, input bit fixed);
    int w, s0, s1, s2;
    int exp_ch[$];
    for (int c = 0; c < 4; c++) if (m[c]) exp_ch.push_back(c);
    s0 = n_start; s1 = n_valid; s2 = n_done;
    bus.ch_mask = m;
    bus.enable  = 1'b1;
    foreach (exp_ch[k]) begin
      wait_start(k == 0 ? SD + 10 : 40, w);
      if (k == 0) chk("tick_latency", 32'(w), SD + 1);
      chk("conv_ch", 32'(bus.conv_ch), 32'(exp_ch[k]));
      chk("busy_scan", 32'(bus.busy), 1);
      if (k == 0) bus.ch_mask = 4'($urandom);
      done_pulse(fixed ? 5 : int'($urandom_range(1, 15)),
                 fixed ? fdat[exp_ch[k]] : 12'($urandom), exp_ch[k], "res");
    end
    repeat (3) @(negedge clk);
    bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("scan_starts", 32'(n_start - s0), 32'(exp_ch.size()));
    chk("scan_results", 32'(n_valid - s1), 32'(exp_ch.size()));
    chk("scan_done_once", 32'(n_done - s2), 1);
    chk("busy_idle", 32'(bus.busy), 0);
  endtask
  initial begin
    int w, s0, s1, s2;
    reset = 1'b0;
    bus.enable = 1'b0; bus.ch_mask = '0; bus.err_clr = 1'b0;
    bus.conv_done = 1'b0; bus.conv_data = '0;
    do_reset();
    run_scan(4'b1011, 1'b1);
    repeat (8) run_scan(4'($urandom_range(1, 15)), 1'b0);
    s0 = n_start; s2 = n_done;
    bus.ch_mask = 4'b0000;
    bus.enable = 1'b1;
    repeat (SD + 20) @(negedge clk);
    bus.enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("mask0_no_start", 32'(n_start - s0), 0);
    chk("mask0_no_done", 32'(n_done - s2), 0);
    chk("mask0_busy", 32'(bus.busy), 0);
    run_scan(4'($urandom_range(1, 15)), 1'b0);
    s0 = n_start; s2 = n_done;
    bus.ch_mask = 4'b1111;
    bus.enable = 1'b1;
    wait_start(SD + 10, w);
    chk("t4_ch0", 32'(bus.conv_ch), 0);
    done_pulse(3, 12'h321, 0, "t4_r0");
    wait_start(40, w);
    chk("t4_ch1", 32'(bus.conv_ch), 1);
    @(negedge clk);
    bus.enable = 1'b0;
    done_pulse(3, 12'h7E1, 1, "t4_r1");
    repeat (30) @(negedge clk);
    chk("t4_no_ch2", 32'(n_start - s0), 2);
    chk("t4_no_done", 32'(n_done - s2), 0);
    chk("t4_busy", 32'(bus.busy), 0);
    s1 = n_valid;
    bus.ch_mask = 4'b0011;
    bus.enable = 1'b1;
    wait_start(SD + 10, w);
    chk("t3_ch0", 32'(bus.conv_ch), 0);
    chk("t5_ovr_clear", 32'(bus.overrun), 0);
    repeat (TO) @(negedge clk);
    chk("t3_to_early", 32'(bus.timeout_err), 0);
    @(negedge clk);
    chk("t3_to_set", 32'(bus.timeout_err), 1);
    chk("t3_no_result", 32'(n_valid - s1), 0);
    wait_start(5, w);
    chk("t3_ch1", 32'(bus.conv_ch), 1);
    done_pulse(2, 12'h0F0, 1, "t3_r1");
    bus.enable = 1'b0;
    chk("t5_ovr_set", 32'(bus.overrun), 1);
    repeat (4) @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    chk("t5_clr_to", 32'(bus.timeout_err), 0);
    chk("t5_clr_ovr", 32'(bus.overrun), 0);
    do_reset();
    s1 = n_valid;
    bus.ch_mask = 4'b0001;
    bus.enable = 1'b1;
    wait_start(SD + 10, w);
    chk("t6_ch0", 32'(bus.conv_ch), 0);
    repeat (2) @(negedge clk);
    bus.enable = 1'b0;
    do_reset();
    bus.conv_done = 1'b1;
    bus.conv_data = 12'hFFF;
    @(negedge clk);
    bus.conv_done = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_no_result", 32'(n_valid - s1), 0);
    chk("t6_outputs", outs(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
